// File: rtl/enigma_ir_letter_queue.sv
// Elastic letter queue between the enigma encoder and the IR transmitter.
// Letters are pushed on each rising edge of the encoder valid level and launched
// one at a time: a single-cycle valid pulse, then the transmitter busy cycle,
// then a fixed idle gap before the next launch may happen.
module enigma_ir_letter_queue #(
  parameter  int DATA_WIDTH   = 5,
  parameter  int DEPTH        = 32,
  parameter  int GAP_CYCLES   = 1000,
  parameter  int BUSY_TIMEOUT = 64,
  localparam int ADDR_W       = $clog2(DEPTH)
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  clear_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid_in,
  input  logic                  ir_busy_in,
  output logic [DATA_WIDTH-1:0] ir_data_out,
  output logic                  ir_valid_out,
  output logic [ADDR_W:0]       count_out,
  output logic                  empty_out,
  output logic                  full_out,
  output logic                  overflow_out,
  output logic                  timeout_out
);

  // One shared timer serves both the busy-rise timeout and the inter-letter gap.
  localparam int TIMER_MAX = (GAP_CYCLES > BUSY_TIMEOUT) ? GAP_CYCLES : BUSY_TIMEOUT;
  localparam int TIMER_W   = $clog2(TIMER_MAX + 1);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    GAP
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0]     wr_ptr_q;
  logic [ADDR_W-1:0]     rd_ptr_q;
  logic [ADDR_W:0]       count_q;
  logic                  prev_valid_q;
  logic                  overflow_q;

  state_e                state_q;
  logic [TIMER_W-1:0]    timer_q;
  logic [DATA_WIDTH-1:0] ir_data_q;
  logic                  ir_valid_q;
  logic                  timeout_q;

  logic empty;
  logic full;
  logic push_edge;
  logic push_ok;
  logic pop;

  assign empty     = (count_q == '0);
  assign full      = (count_q == (ADDR_W+1)'(DEPTH));
  assign push_edge = data_valid_in & ~prev_valid_q;
  // Fullness is judged at the start of the cycle, so a same-cycle pop never rescues a push.
  assign push_ok   = push_edge & ~full & ~clear_in;
  // The only pop is the IDLE -> LAUNCH transition.
  assign pop       = (state_q == IDLE) & ~empty & ~clear_in;

  // Letter storage: written on an accepted push only.
  // NOTE: the storage array has no reset; the pointers and count define which entries are
  // meaningful, so clearing the contents would only cost logic and block RAM inference.
  always_ff @(posedge clk_in) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= data_in;
    end
  end

  // Queue bookkeeping: edge detect, pointers, occupancy and the sticky overflow flag.
  // NOTE: every register here uses non-blocking assignment so all of them update together
  // from the values that were present before the clock edge.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      prev_valid_q <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
    end else begin
      prev_valid_q <= data_valid_in;
      if (clear_in) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        overflow_q <= 1'b0;
      end else begin
        // DEPTH is a power of two, so the pointers wrap DEPTH-1 -> 0 naturally.
        if (push_ok) begin
          wr_ptr_q <= wr_ptr_q + 1'b1;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + 1'b1;
        end
        if (push_edge && full) begin
          overflow_q <= 1'b1;
        end
        case ({push_ok, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // Launch sequencer: pops a letter, pulses valid, then waits out busy and the gap.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q    <= IDLE;
      timer_q    <= '0;
      ir_data_q  <= '0;
      ir_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else if (clear_in) begin
      // The presented letter is deliberately kept; only control state is flushed.
      state_q    <= IDLE;
      timer_q    <= '0;
      ir_valid_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      ir_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pop) begin
            ir_data_q  <= mem_q[rd_ptr_q];
            ir_valid_q <= 1'b1;
            state_q    <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer_q <= '0;
          state_q <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (ir_busy_in) begin
            state_q <= WAIT_DONE;
          end else if (timer_q == TIMER_W'(BUSY_TIMEOUT - 1)) begin
            // The transmitter never acknowledged: the letter is lost, not retried.
            timeout_q <= 1'b1;
            timer_q   <= '0;
            state_q   <= GAP;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!ir_busy_in) begin
            timer_q <= '0;
            state_q <= GAP;
          end
        end
        GAP: begin
          if (timer_q == TIMER_W'(GAP_CYCLES - 1)) begin
            timer_q <= '0;
            state_q <= IDLE;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign ir_data_out  = ir_data_q;
  assign ir_valid_out = ir_valid_q;
  assign count_out    = count_q;
  assign empty_out    = empty;
  assign full_out     = full;
  assign overflow_out = overflow_q;
  assign timeout_out  = timeout_q;

endmodule

// File: tb/tb_enigma_ir_letter_queue.sv
// Testbench for enigma_ir_letter_queue. A queue-based reference model tracks the letters
// that should be held and the order they must be launched in; scenario tasks add
// cycle-exact checks of launch latency, busy/gap serialisation, timeout, clear and reset.
module tb_enigma_ir_letter_queue;

  localparam int DW    = 5;
  localparam int DEPTH = 32;
  localparam int GAP   = 40;
  localparam int BT    = 64;
  localparam int AW    = $clog2(DEPTH);

  logic          clk_in = 1'b0;
  logic          rst_n_in = 1'b0;
  logic          clear_in = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_valid_in = 1'b0;
  logic          ir_busy_in = 1'b0;
  logic [DW-1:0] ir_data_out;
  logic          ir_valid_out;
  logic [AW:0]   count_out;
  logic          empty_out;
  logic          full_out;
  logic          overflow_out;
  logic          timeout_out;

  enigma_ir_letter_queue #(
    .DATA_WIDTH  (DW),
    .DEPTH       (DEPTH),
    .GAP_CYCLES  (GAP),
    .BUSY_TIMEOUT(BT)
  ) dut (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .clear_in     (clear_in),
    .data_in      (data_in),
    .data_valid_in(data_valid_in),
    .ir_busy_in   (ir_busy_in),
    .ir_data_out  (ir_data_out),
    .ir_valid_out (ir_valid_out),
    .count_out    (count_out),
    .empty_out    (empty_out),
    .full_out     (full_out),
    .overflow_out (overflow_out),
    .timeout_out  (timeout_out)
  );

  always #5 clk_in = ~clk_in;

  typedef enum {BUSY_MANUAL, BUSY_AUTO} busy_mode_e;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            launch_count = 0;
  bit            launched = 0;
  logic [DW-1:0] model_q [$];
  bit            model_ovf = 0;
  bit            vlast = 0;
  busy_mode_e    busy_mode = BUSY_MANUAL;
  int            bwait = 0;
  int            blen = 0;

  // One clock cycle: advance, update the reference model from what was driven, and compare.
  task automatic tick();
    bit            pend_push;
    bit            pend_clear;
    logic [DW-1:0] pend_data;
    logic [DW-1:0] exp_letter;
    logic [AW:0]   exp_cnt;
    int            sz0;
    pend_push  = data_valid_in && !vlast && rst_n_in;
    pend_clear = clear_in;
    pend_data  = data_in;
    vlast      = rst_n_in ? data_valid_in : 1'b0;
    sz0        = model_q.size();
    @(posedge clk_in);
    #1;
    cyc++;
    launched = 0;
    if (!rst_n_in) begin
      model_q.delete();
      model_ovf = 0;
    end else if (pend_clear) begin
      model_q.delete();
      model_ovf = 0;
    end else if (pend_push) begin
      if (sz0 < DEPTH) model_q.push_back(pend_data);
      else model_ovf = 1;
    end
    if (ir_valid_out === 1'b1) begin
      launched = 1;
      launch_count++;
      checks++;
      if (!rst_n_in || pend_clear || sz0 == 0) begin
        failures++;
        $display("FAIL unexpected_launch cycle=%0d ir_valid_out=1 required=0", cyc);
      end else begin
        exp_letter = model_q.pop_front();
        checks++;
        if (ir_data_out !== exp_letter) begin
          failures++;
          $display("FAIL letter_order cycle=%0d got=%0d exp=%0d", cyc, ir_data_out, exp_letter);
        end
      end
    end
    exp_cnt = (AW+1)'(model_q.size());
    checks++;
    if (count_out !== exp_cnt) begin
      failures++;
      $display("FAIL count cycle=%0d got=%0d exp=%0d", cyc, count_out, exp_cnt);
    end
    checks++;
    if (empty_out !== (model_q.size() == 0) || full_out !== (model_q.size() == DEPTH)) begin
      failures++;
      $display("FAIL empty_full cycle=%0d got=%b/%b exp_size=%0d", cyc, empty_out, full_out,
               model_q.size());
    end
    checks++;
    if (overflow_out !== model_ovf) begin
      failures++;
      $display("FAIL overflow cycle=%0d got=%b exp=%b", cyc, overflow_out, model_ovf);
    end
    if (busy_mode == BUSY_AUTO) begin
      if (bwait > 0) begin
        bwait--;
        if (bwait == 0) ir_busy_in = 1'b1;
      end else if (ir_busy_in) begin
        if (blen > 0) blen--;
        if (blen == 0) ir_busy_in = 1'b0;
      end
      if (launched) begin
        bwait = $urandom_range(1, 4);
        blen  = $urandom_range(1, 8);
      end
    end
  endtask

  task automatic push(input logic [DW-1:0] d, input int hi, input int lo);
    data_in       = d;
    data_valid_in = 1'b1;
    repeat (hi) tick();
    data_valid_in = 1'b0;
    repeat (lo) tick();
  endtask

  task automatic wait_launch(input int max_cycles, output int waited);
    waited = 0;
    do begin
      tick();
      waited++;
    end while (!launched && waited < max_cycles);
    checks++;
    if (!launched) begin
      failures++;
      $display("FAIL launch_wait waited=%0d launched=0 required=1", waited);
    end
  endtask

  // Acknowledge the letter just launched and let the sequencer return to idle.
  task automatic finish_letter();
    ir_busy_in = 1'b1;
    repeat (3) tick();
    ir_busy_in = 1'b0;
    repeat (GAP + 5) tick();
  endtask

  task automatic clear_pulse();
    clear_in = 1'b1;
    tick();
    clear_in = 1'b0;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++) begin
      data_valid_in = i[0];
      data_in       = DW'($urandom_range(0, 25));
      tick();
      checks++;
      if (ir_valid_out !== 1'b0 || ir_data_out !== '0 || timeout_out !== 1'b0 ||
          empty_out !== 1'b1) begin
        failures++;
        $display("FAIL reset_outputs valid=%b data=%0d timeout=%b empty=%b exp=0/0/0/1",
                 ir_valid_out, ir_data_out, timeout_out, empty_out);
      end
    end
    data_valid_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_single_letter();
    int i;
    busy_mode  = BUSY_MANUAL;
    ir_busy_in = 1'b0;
    data_in       = 7;
    data_valid_in = 1'b1;
    tick();
    checks++;
    if (count_out !== 1 || ir_valid_out !== 1'b0) begin
      failures++;
      $display("FAIL latency_n1 count=%0d valid=%b exp=1/0", count_out, ir_valid_out);
    end
    tick();
    checks++;
    if (ir_valid_out !== 1'b1 || ir_data_out !== 7 || count_out !== 0) begin
      failures++;
      $display("FAIL latency_n2 valid=%b data=%0d count=%0d exp=1/7/0", ir_valid_out,
               ir_data_out, count_out);
    end
    // Busy high for 50 cycles from here; a second letter is queued meanwhile.
    ir_busy_in = 1'b1;
    i = 0;
    do begin
      tick();
      i++;
      if (i == 8) data_valid_in = 1'b0;
      if (i == 10) begin
        data_in       = 12;
        data_valid_in = 1'b1;
      end
      if (i == 12) data_valid_in = 1'b0;
      if (i == 50) ir_busy_in = 1'b0;
    end while (!launched && i < 52 + GAP + 20);
    // Busy low is first seen 51 cycles after launch, GAP cycles of gap, one idle cycle.
    checks++;
    if (!launched || i != 52 + GAP) begin
      failures++;
      $display("FAIL gap_spacing launched=%b cycles=%0d exp=%0d", launched, i, 52 + GAP);
    end
    finish_letter();
  endtask

  task automatic test_order_wrap();
    int base;
    int i;
    base      = launch_count;
    busy_mode = BUSY_AUTO;
    for (int k = 0; k < 40; k++) begin
      push(DW'(k % 26), $urandom_range(1, 3), $urandom_range(20, 60));
    end
    i = 0;
    while (model_q.size() != 0 && i < 4000) begin
      tick();
      i++;
    end
    repeat (GAP + 30) tick();
    busy_mode  = BUSY_MANUAL;
    ir_busy_in = 1'b0;
    checks++;
    if (launch_count - base != 40) begin
      failures++;
      $display("FAIL order_launches got=%0d exp=40", launch_count - base);
    end
  endtask

  task automatic test_overflow();
    int base;
    base       = launch_count;
    ir_busy_in = 1'b1;
    push(1, 1, 1);
    for (int k = 0; k < 33; k++) begin
      push(DW'((k + 2) % 26), 1, 1);
      if (k == 31) begin
        checks++;
        if (count_out !== 32 || full_out !== 1'b1 || overflow_out !== 1'b0) begin
          failures++;
          $display("FAIL full_at_32 count=%0d full=%b ovf=%b exp=32/1/0", count_out, full_out,
                   overflow_out);
        end
      end
    end
    checks++;
    if (count_out !== 32 || overflow_out !== 1'b1 || launch_count - base != 1) begin
      failures++;
      $display("FAIL overflow_drop count=%0d ovf=%b launches=%0d exp=32/1/1", count_out,
               overflow_out, launch_count - base);
    end
    repeat (5) tick();
    clear_pulse();
    checks++;
    if (overflow_out !== 1'b0 || count_out !== 0) begin
      failures++;
      $display("FAIL overflow_clear ovf=%b count=%0d exp=0/0", overflow_out, count_out);
    end
    ir_busy_in = 1'b0;
    repeat (2) tick();
  endtask

  task automatic test_timeout();
    int w;
    int i;
    ir_busy_in    = 1'b0;
    data_in       = 3;
    data_valid_in = 1'b1;
    wait_launch(10, w);
    data_valid_in = 1'b0;
    for (i = 1; i <= BT + 1; i++) begin
      tick();
      if (i == 3) begin
        data_in       = 4;
        data_valid_in = 1'b1;
      end
      if (i == 5) data_valid_in = 1'b0;
      checks++;
      if (timeout_out !== (i >= BT + 1)) begin
        failures++;
        $display("FAIL timeout_timing cycle_after_launch=%0d got=%b exp=%b", i, timeout_out,
                 (i >= BT + 1));
      end
    end
    i = BT + 1;
    do begin
      tick();
      i++;
    end while (!launched && i < BT + GAP + 30);
    checks++;
    if (!launched || i != BT + 2 + GAP || timeout_out !== 1'b1) begin
      failures++;
      $display("FAIL timeout_next_launch launched=%b cycles=%0d timeout=%b exp=%0d/1", launched,
               i, timeout_out, BT + 2 + GAP);
    end
    clear_pulse();
    checks++;
    if (timeout_out !== 1'b0) begin
      failures++;
      $display("FAIL timeout_clear got=%b exp=0", timeout_out);
    end
    tick();
  endtask

  task automatic test_clear();
    int w;
    int base;
    data_in       = 9;
    data_valid_in = 1'b1;
    wait_launch(10, w);
    data_valid_in = 1'b0;
    ir_busy_in    = 1'b1;
    repeat (3) tick();
    for (int k = 0; k < 5; k++) push(DW'($urandom_range(0, 25)), 1, 1);
    checks++;
    if (count_out !== 5) begin
      failures++;
      $display("FAIL clear_prefill count=%0d exp=5", count_out);
    end
    data_in       = 20;
    data_valid_in = 1'b1;
    clear_pulse();
    checks++;
    if (count_out !== 0 || empty_out !== 1'b1 || ir_valid_out !== 1'b0 ||
        overflow_out !== 1'b0 || timeout_out !== 1'b0 || ir_data_out !== 9) begin
      failures++;
      $display("FAIL clear_state count=%0d empty=%b valid=%b data=%0d exp=0/1/0/9", count_out,
               empty_out, ir_valid_out, ir_data_out);
    end
    data_valid_in = 1'b0;
    ir_busy_in    = 1'b0;
    base          = launch_count;
    repeat (100) tick();
    checks++;
    if (launch_count != base) begin
      failures++;
      $display("FAIL clear_quiet launches=%0d exp=0", launch_count - base);
    end
    data_in       = 11;
    data_valid_in = 1'b1;
    wait_launch(10, w);
    data_valid_in = 1'b0;
    finish_letter();
  endtask

  task automatic test_async_reset();
    int w;
    int base;
    data_in       = 13;
    data_valid_in = 1'b1;
    wait_launch(10, w);
    data_valid_in = 1'b0;
    ir_busy_in    = 1'b1;
    repeat (3) tick();
    ir_busy_in = 1'b0;
    repeat (5) tick();
    for (int k = 0; k < 3; k++) push(DW'($urandom_range(0, 25)), 1, 1);
    // Mid-gap, off the clock edge.
    #2;
    rst_n_in = 1'b0;
    #1;
    checks++;
    if (count_out !== 0 || empty_out !== 1'b1 || full_out !== 1'b0 || ir_valid_out !== 1'b0 ||
        ir_data_out !== '0 || overflow_out !== 1'b0 || timeout_out !== 1'b0) begin
      failures++;
      $display("FAIL async_reset count=%0d empty=%b valid=%b data=%0d exp=0/1/0/0", count_out,
               empty_out, ir_valid_out, ir_data_out);
    end
    for (int i = 0; i < 4; i++) begin
      data_valid_in = ~data_valid_in;
      tick();
    end
    data_valid_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    base     = launch_count;
    repeat (100) tick();
    checks++;
    if (launch_count != base) begin
      failures++;
      $display("FAIL reset_quiet launches=%0d exp=0", launch_count - base);
    end
    data_in       = 17;
    data_valid_in = 1'b1;
    wait_launch(10, w);
    data_valid_in = 1'b0;
    finish_letter();
  endtask

  initial begin
    test_reset();
    test_single_letter();
    test_order_wrap();
    test_overflow();
    test_timeout();
    test_clear();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
